// File: rtl/ysyx_23060208_arb_pkg.sv
// Shared types and constants for the dsram read-port arbiter.
package ysyx_23060208_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR0  = 3'd1,
        R0   = 3'd2,
        AR1  = 3'd3,
        R1   = 3'd4
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060208_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not own the port last wins.
module ysyx_23060208_rr_pick
    import ysyx_23060208_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Shares the dsram AR/R channels between IFU (0) and LSU (1), one whole read at a time.
module ysyx_23060208_rd_arbiter
    import ysyx_23060208_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [DATA_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready
);

    arb_state_e state, state_n;
    logic       last, last_n;
    logic       gnt_valid, gnt_id;

    ysyx_23060208_rr_pick u_pick (
        .req       ({m1_arvalid, m0_arvalid}),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Owner only changes from IDLE, so AR and R of one transaction always share a master.
    always_comb begin
        state_n = state;
        last_n  = last;
        case (state)
            IDLE: if (gnt_valid) state_n = gnt_id ? AR1 : AR0;
            AR0:  if (s_arvalid && s_arready) state_n = R0;
            R0:   if (s_rvalid && s_rready) begin
                      state_n = IDLE;
                      last_n  = 1'b0;
                  end
            AR1:  if (s_arvalid && s_arready) state_n = R1;
            R1:   if (s_rvalid && s_rready) begin
                      state_n = IDLE;
                      last_n  = 1'b1;
                  end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            last  <= last_n;
        end
    end

    always_comb begin
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = RESP_OKAY;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = RESP_OKAY;
        m1_rvalid  = 1'b0;
        case (state)
            AR0: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid;
                m0_arready = s_arready;
            end
            R0: begin
                m0_rdata  = s_rdata;
                m0_rresp  = s_rresp;
                m0_rvalid = s_rvalid;
                s_rready  = m0_rready;
            end
            AR1: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid;
                m1_arready = s_arready;
            end
            R1: begin
                m1_rdata  = s_rdata;
                m1_rresp  = s_rresp;
                m1_rvalid = s_rvalid;
                s_rready  = m1_rready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Directed bench for the dsram read arbiter with an expected-transaction scoreboard.
module tb_ysyx_23060208_rd_arbiter;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] m0_araddr, m1_araddr, s_araddr, s_rdata;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic         m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [1:0]   m0_rresp, m1_rresp, s_rresp;
    logic         m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic         s_arvalid, s_arready, s_rvalid, s_rready;

    typedef struct {
        bit           id;
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } txn_t;

    txn_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    ysyx_23060208_rd_arbiter #(.DATA_WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [W-1:0] data_of(input logic [W-1:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Every DUT output, concatenated, for the all-zero checks.
    function automatic logic [63:0] all_out();
        return {32'(m0_rdata | m1_rdata | s_araddr),
                m0_rresp, m1_rresp,
                m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready};
    endfunction

    task automatic wait_ar(output bit ok);
        int n = 0;
        #1;
        while (!s_arvalid && n < 20) begin
            tick();
            n++;
        end
        ok = s_arvalid;
        if (!ok) check("ar_timeout", 0, 1);
    endtask

    // Acts as dsram for the transaction at the head of the scoreboard and checks the routing.
    task automatic serve(input int lat, input int bp);
        txn_t e;
        bit   ok;
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        wait_ar(ok);
        if (!ok) return;
        s_arready = 1'b1;
        #1;
        check("grant_owner", {m1_arready, m0_arready}, e.id ? 2'b10 : 2'b01);
        check("s_araddr", s_araddr, e.addr);
        tick();
        s_arready = 1'b0;
        if (e.id) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        if (bp > 0) begin
            if (e.id) m1_rready = 1'b0; else m0_rready = 1'b0;
        end
        for (int i = 0; i < lat; i++) begin
            #1;
            check("no_ar_in_r", s_arvalid, 0);
            check("rvalid_early", m0_rvalid | m1_rvalid, 0);
            tick();
        end
        s_rdata  = e.data;
        s_rresp  = 2'b00;
        s_rvalid = 1'b1;
        for (int i = 0; i < bp; i++) begin
            #1;
            check("bp_s_rready", s_rready, 0);
            check("bp_rvalid", e.id ? m1_rvalid : m0_rvalid, 1);
            check("bp_other_arready", m0_arready | m1_arready | s_arvalid, 0);
            tick();
        end
        if (e.id) m1_rready = 1'b1; else m0_rready = 1'b1;
        #1;
        check("rdata", e.id ? m1_rdata : m0_rdata, e.data);
        check("rvalid", {m1_rvalid, m0_rvalid}, e.id ? 2'b10 : 2'b01);
        check("other_rdata", e.id ? m0_rdata : m1_rdata, 0);
        check("s_rready", s_rready, 1);
        tick();
        s_rvalid = 1'b0;
        s_rdata  = '0;
    endtask

    initial begin
        txn_t t;
        bit   ok;
        reset = 1'b1;
        m0_araddr = '0; m1_araddr = '0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
        #1;
        check("reset_outputs", all_out(), 0);
        tick();
        tick();
        reset = 1'b0;

        // Stray slave data in IDLE is never accepted.
        s_rvalid = 1'b1;
        #1;
        check("idle_s_rready", s_rready, 0);
        check("idle_outputs", all_out(), 0);
        s_rvalid = 1'b0;
        tick();

        // Solo m0 read.
        m0_araddr = 32'h8000_0010; m0_arvalid = 1'b1;
        t = '{id: 1'b0, addr: 32'h8000_0010, data: 32'hDEAD_BEEF};
        sb.push_back(t);
        serve(2, 0);

        // Simultaneous first requests after a fresh reset: m0 first.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        m0_araddr = 32'h0000_0100; m0_arvalid = 1'b1;
        m1_araddr = 32'h0000_0200; m1_arvalid = 1'b1;
        t = '{id: 1'b0, addr: 32'h0000_0100, data: data_of(32'h0000_0100)};
        sb.push_back(t);
        t = '{id: 1'b1, addr: 32'h0000_0200, data: data_of(32'h0000_0200)};
        sb.push_back(t);
        serve(1, 0);
        #1;
        check("m1_waits", m1_arready, 0);
        serve(1, 0);

        // Sustained contention: strict alternation starting with m0 (last owner was m1).
        for (int k = 0; k < 6; k++) begin
            t = '{id: k[0], addr: 32'h1000 + 32'(k * 4), data: data_of(32'h1000 + 32'(k * 4))};
            sb.push_back(t);
        end
        m0_araddr = 32'h1000; m0_arvalid = 1'b1;
        m1_araddr = 32'h1004; m1_arvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            serve(1 + (k % 2), 0);
            if (k + 2 < 6) begin
                if (k[0]) begin
                    m1_araddr = 32'h1000 + 32'((k + 2) * 4); m1_arvalid = 1'b1;
                end else begin
                    m0_araddr = 32'h1000 + 32'((k + 2) * 4); m0_arvalid = 1'b1;
                end
            end
        end

        // Backpressure from m1 while m0 waits.
        m1_araddr = 32'h0000_3000; m1_arvalid = 1'b1;
        tick();
        m0_araddr = 32'h0000_4000; m0_arvalid = 1'b1;
        t = '{id: 1'b1, addr: 32'h0000_3000, data: data_of(32'h0000_3000)};
        sb.push_back(t);
        t = '{id: 1'b0, addr: 32'h0000_4000, data: data_of(32'h0000_4000)};
        sb.push_back(t);
        serve(1, 3);
        serve(2, 0);

        // Reset in the middle of an m0 data phase.
        m0_araddr = 32'h0000_5000; m0_arvalid = 1'b1;
        wait_ar(ok);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0; m0_arvalid = 1'b0;
        s_rdata = 32'h1234_5678; s_rvalid = 1'b1;
        #1;
        check("r0_before_reset", m0_rvalid, 1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", all_out(), 0);
        s_rvalid = 1'b0; s_rdata = '0;
        tick();
        reset = 1'b0;

        // Fresh m1 request after reset, then a tie that m0 must win.
        m1_araddr = 32'h0000_6000; m1_arvalid = 1'b1;
        t = '{id: 1'b1, addr: 32'h0000_6000, data: data_of(32'h0000_6000)};
        sb.push_back(t);
        serve(1, 0);
        m0_araddr = 32'h0000_7000; m0_arvalid = 1'b1;
        m1_araddr = 32'h0000_7100; m1_arvalid = 1'b1;
        t = '{id: 1'b0, addr: 32'h0000_7000, data: data_of(32'h0000_7000)};
        sb.push_back(t);
        t = '{id: 1'b1, addr: 32'h0000_7100, data: data_of(32'h0000_7100)};
        sb.push_back(t);
        serve(1, 0);
        serve(1, 0);

        #1;
        check("sb_drained", sb.size(), 0);
        check("final_idle", all_out(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
